// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, imem issue, response FIFO, decode handshake
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 1,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_fault,
`endif
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = 5;
  localparam int SW = (IMEM_LATENCY > 0) ? IMEM_LATENCY : 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
`endif

  state_t          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            issue;
  logic            flush;
  logic            fault_hold;
  logic [31:0]     push_pc;
  logic [OW-1:0]   inflight_n;
  logic [OW-1:0]   occupancy;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fault_hold = (state_q == S_FAULT);
`else
  assign fault_hold = 1'b0;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign flush    = redirect_valid;
  assign if_valid = (count != '0) && !redirect_valid && !fault_hold;
  assign pop      = if_valid && if_ready;
  assign if_pc    = fifo_pc[rd_ptr];
  assign if_instr = fifo_instr[rd_ptr];
  assign busy     = (inflight_n != '0) || (count != '0);

  // The entry popped this cycle frees its slot in time for a fetch issued now.
  assign occupancy = inflight_n + OW'(count) - OW'(pop);
  assign issue     = (state_q == S_RUN) && !halt && !redirect_valid &&
                     (occupancy < OW'(FIFO_DEPTH));
  assign imem_req  = issue;
  assign imem_addr = pc_q;

  generate
    if (IMEM_LATENCY == 0) begin : g_comb_rom
      assign push       = issue;
      assign push_pc    = pc_q;
      assign inflight_n = '0;
    end else begin : g_pipe
      logic [SW-1:0] stage_v;
      logic [31:0]   stage_pc [SW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_v <= '0;
          for (int i = 0; i < SW; i++) stage_pc[i] <= '0;
        end else begin
          if (flush) begin
            stage_v <= '0;
          end else begin
            stage_v[0] <= issue;
            for (int i = 1; i < SW; i++) stage_v[i] <= stage_v[i-1];
          end
          stage_pc[0] <= pc_q;
          for (int i = 1; i < SW; i++) stage_pc[i] <= stage_pc[i-1];
        end
      end

      always_comb begin
        inflight_n = '0;
        for (int i = 0; i < SW; i++) inflight_n = inflight_n + OW'(stage_v[i]);
      end

      assign push    = stage_v[SW-1] && !flush;
      assign push_pc = stage_pc[SW-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= push_pc;
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always @(posedge clk) begin
    if (rst_n && !flush && push && !pop) assert (count != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= S_BOOT;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      if (redirect_valid) pc_q <= redirect_pc & ~32'd3;
      else if (issue)     pc_q <= pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        state_q     <= S_FAULT;
        fetch_fault <= 1'b1;
      end else
`endif
      case (state_q)
        S_BOOT: state_q <= S_RUN;
        S_RUN:  if (halt) state_q <= S_HALT;
        S_HALT: if (!halt) state_q <= S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: begin
          if (redirect_valid) begin
            fetch_fault <= 1'b0;
            state_q     <= halt ? S_HALT : S_RUN;
          end
        end
`endif
        default: state_q <= S_BOOT;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that sequences the instruction memory: owns the fetch PC, issues word addresses to the instruction memory, captures returned instructions and hands {pc, instr} pairs to decode over a valid/ready handshake. Tolerates an instruction memory read latency of 0 (combinational ROM) or more cycles. Handles redirects (branch/jump targets) by flushing in-flight fetches, and handles halt requests. Sits between the instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
IMEM_LATENCY, 1, cycles from imem_req to valid imem_rdata; legal 0..3.
FIFO_DEPTH, 2, response buffer entries; legal 2..8. Full throughput needs FIFO_DEPTH >= IMEM_LATENCY+1.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  byte address to instruction memory, bits[1:0]=0
imem_req  out  1  fetch issued this cycle
imem_rdata  in  32  instruction, valid IMEM_LATENCY cycles after imem_req
if_valid  out  1  if_pc/if_instr hold a fetched instruction
if_ready  in  1  decode accepts
if_pc  out  32  PC of presented instruction
if_instr  out  32  presented instruction
redirect_valid  in  1  load new fetch PC, flush
redirect_pc  in  32  redirect target
halt  in  1  stop issuing new fetches
busy  out  1  in-flight fetches or buffered entries exist

Behaviour:
- Reset (rst_n=0, async): pc_q=RESET_PC, state=S_BOOT, FIFO empty, in-flight valid bits cleared; imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, busy=0.
- FSM: S_BOOT -> S_RUN unconditionally after one cycle (no issue in S_BOOT). S_RUN -> S_HALT when halt=1. S_HALT -> S_RUN when halt=0. Redirect does not change state.
- Issue: imem_req=1 iff state==S_RUN, halt=0, redirect_valid=0, (inflight+fifo_count) < FIFO_DEPTH. imem_addr=pc_q. On issue pc_q<=pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- In-flight tracking: IMEM_LATENCY-stage shift register of {valid, pc}. When the stage leaves the pipeline, {pc, imem_rdata} is written into the FIFO. Latency 0: written at the end of the issue cycle.
- Output: if_valid = fifo_not_empty && !redirect_valid; if_pc/if_instr = FIFO head (registered). Pop on if_valid && if_ready. Push and pop in the same cycle are allowed. Order is strictly preserved. Capacity check makes FIFO overflow impossible; an overflow is an assertion failure.
- Fetch-to-output latency: if_valid first asserts IMEM_LATENCY+1 cycles after the issuing cycle.
- Backpressure: if_ready=0 holds head data stable. Issue stops once inflight+count reaches FIFO_DEPTH.
- Redirect (priority over everything except reset): in that cycle FIFO cleared, all in-flight valid bits cleared (late data dropped), no issue, no pop. pc_q<=redirect_pc with bits[1:0] masked to 0. The target is issued next cycle if in S_RUN.
- Halt: no new issue. In-flight fetches still complete into the FIFO and drain normally. Redirect during S_HALT updates pc_q and flushes.
- Redirect and halt in the same cycle: redirect applied, state moves to S_HALT.
- busy = (inflight != 0) || fifo_not_empty.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: adds output fetch_fault (1 bit, reset 0). A redirect with redirect_pc[1:0]!=0 flushes as normal, sets fetch_fault=1 and enters S_FAULT: no issue, if_valid=0. S_FAULT exits only on an aligned redirect, which clears fetch_fault and returns to S_RUN, or S_HALT if halt=1.
- Undefined: no port, no S_FAULT; low bits silently masked.

Test Plan:
- Reset, LATENCY=1, DEPTH=2, if_ready=1, ROM word n=0x1000_0000+n: imem_addr 0,4,8… from cycle 1 after reset release; if_valid from cycle 3 with if_pc=0, if_instr=0x1000_0000, then one per cycle.
- Hold if_ready=0 for 10 cycles: at most 2 imem_req issued; if_pc stays 0; after release if_pc 0,4,8 in order, none lost or duplicated.
- Redirect to 0x40 with 1 in flight and 1 buffered: if_valid=0 in redirect cycle; next if_pc=0x40; the dropped PCs never appear on the output.
- halt=1 for 5 cycles mid-stream: imem_req=0 throughout; buffered entries drain; busy falls to 0; resume at the next sequential PC.
- Redirect to 0xFFFF_FFF8: if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x42: fetch_fault=1 and no imem_req; redirect to 0x80 clears fetch_fault and next if_pc=0x80. Without the macro, 0x42 fetches from 0x40.
